// File: rtl/axis_bcast_pkg.sv
// ---------------------------------------------------------------------------
// axis_bcast_pkg
//   Shared definitions for the AXI4-Stream 1-to-2 broadcaster.
//   - AXIS_DATA_WIDTH_DEF : default TDATA width
//   - NUM_OUTPUTS         : number of broadcast master ports
//   - STATS_W             : width of the optional statistics counters
//   - axis_beat_t         : one stream beat {data, last} at the default width
// ---------------------------------------------------------------------------
package axis_bcast_pkg;

  localparam int AXIS_DATA_WIDTH_DEF = 32;
  localparam int NUM_OUTPUTS         = 2;
  localparam int STATS_W             = 32;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH_DEF-1:0] data;
    logic                           last;
  } axis_beat_t;

endpackage

// File: rtl/axis_bcast_out_slot.sv
// ---------------------------------------------------------------------------
// axis_bcast_out_slot
//   Pending-beat tracker for one broadcast master port. The slot goes pending
//   when the shared holding register is loaded and clears once its own sink
//   has taken the beat.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   acc        in   a new beat is being loaded into the holding register
//   m_tready   in   sink ready for this port
//   m_tvalid   out  beat pending on this port (registered, never from m_tready)
//   slot_free  out  slot can take a new beat this cycle (empty or draining now)
// ---------------------------------------------------------------------------
module axis_bcast_out_slot
  import axis_bcast_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic m_tready,
  output logic m_tvalid,
  output logic slot_free
);

  logic pend_q;
  logic fire;

  assign fire      = pend_q & m_tready;
  assign slot_free = ~pend_q | fire;
  assign m_tvalid  = pend_q;

  // A new accept always re-arms the slot, even if the old beat fires in the
  // same cycle, so back-to-back beats leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (acc) begin
      pend_q <= 1'b1;
    end else if (fire) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_stream_bcast2.sv
// ---------------------------------------------------------------------------
// axis_stream_bcast2
//   Single-clock AXI4-Stream 1-to-2 broadcaster. Each accepted input beat is
//   delivered exactly once, unmodified, to both master ports. The outputs drain
//   independently; the input stalls until both have consumed the current beat.
//
// Parameters:
//   DATA_WIDTH      TDATA width on all ports (default 32)
//
// Ports:
//   AXIS_ACLK       in   clock, rising edge
//   AXIS_ARESETN    in   asynchronous active-low reset
//   S_AXIS_*        in/out  slave side: TDATA, TVALID, TLAST in; TREADY out
//   M_AXIS_*1       master port 1: TDATA, TVALID, TLAST out; TREADY in
//   M_AXIS_*2       master port 2: TDATA, TVALID, TLAST out; TREADY in
//
// Optional build macro AXIS_BCAST_STATS_EN adds:
//   beat_count      out  32-bit count of accepted beats (wraps)
//   pkt_count       out  32-bit count of accepted beats with TLAST=1 (wraps)
// ---------------------------------------------------------------------------
module axis_stream_bcast2
  import axis_bcast_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH_DEF
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA1,
  output logic                  M_AXIS_TVALID1,
  output logic                  M_AXIS_TLAST1,
  input  logic                  M_AXIS_TREADY1,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA2,
  output logic                  M_AXIS_TVALID2,
  output logic                  M_AXIS_TLAST2,
  input  logic                  M_AXIS_TREADY2
`ifdef AXIS_BCAST_STATS_EN
  ,
  output logic [STATS_W-1:0]    beat_count,
  output logic [STATS_W-1:0]    pkt_count
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  beat_t                  hold_p0;
  logic [NUM_OUTPUTS-1:0] m_tready;
  logic [NUM_OUTPUTS-1:0] m_tvalid;
  logic [NUM_OUTPUTS-1:0] slot_free;
  logic                   s_tready;
  logic                   acc;

  assign m_tready = {M_AXIS_TREADY2, M_AXIS_TREADY1};

  // Ready looks only at the output side (pending flags and sink readies) and
  // reset, never at S_AXIS_TVALID, so no valid->ready loop can form upstream.
  assign s_tready = AXIS_ARESETN & (&slot_free);
  assign acc      = S_AXIS_TVALID & s_tready;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_slot
    axis_bcast_out_slot u_slot (
      .clk       (AXIS_ACLK),
      .rst_n     (AXIS_ARESETN),
      .acc       (acc),
      .m_tready  (m_tready[i]),
      .m_tvalid  (m_tvalid[i]),
      .slot_free (slot_free[i])
    );
  end

  // ---- stage 0: shared holding register (loaded only on accept) ----
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      hold_p0 <= '0;
    end else if (acc) begin
      hold_p0 <= {S_AXIS_TDATA, S_AXIS_TLAST};
    end
  end

  assign S_AXIS_TREADY  = s_tready;
  assign M_AXIS_TVALID1 = m_tvalid[0];
  assign M_AXIS_TVALID2 = m_tvalid[1];
  assign M_AXIS_TDATA1  = hold_p0.data;
  assign M_AXIS_TLAST1  = hold_p0.last;
  assign M_AXIS_TDATA2  = hold_p0.data;
  assign M_AXIS_TLAST2  = hold_p0.last;

`ifdef AXIS_BCAST_STATS_EN
  logic [STATS_W-1:0] beat_cnt_q;
  logic [STATS_W-1:0] pkt_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else if (acc) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
      if (S_AXIS_TLAST) begin
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
    end
  end

  assign beat_count = beat_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_stream_bcast2.sv
// ---------------------------------------------------------------------------
// tb_axis_stream_bcast2
//   Self-checking bench for axis_stream_bcast2. Accepted input beats are
//   pushed into one expected queue per output; a monitor pops and compares on
//   every output handshake. Directed checks cover reset, streaming latency,
//   skewed sinks and backpressure. Define AXIS_BCAST_STATS_EN to also exercise
//   the statistics counters.
// ---------------------------------------------------------------------------
module tb_axis_stream_bcast2;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata1, m_tdata2;
  logic          m_tvalid1, m_tvalid2;
  logic          m_tlast1, m_tlast2;
  logic          m_tready1, m_tready2;
  logic          rnd_rdy;
`ifdef AXIS_BCAST_STATS_EN
  logic [31:0]   beat_count, pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW:0] exp1[$];
  logic [DW:0] exp2[$];
  logic [DW:0] e1, e2;

  always #5 clk = ~clk;

  axis_stream_bcast2 #(.DATA_WIDTH(DW)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA1  (m_tdata1),
    .M_AXIS_TVALID1 (m_tvalid1),
    .M_AXIS_TLAST1  (m_tlast1),
    .M_AXIS_TREADY1 (m_tready1),
    .M_AXIS_TDATA2  (m_tdata2),
    .M_AXIS_TVALID2 (m_tvalid2),
    .M_AXIS_TLAST2  (m_tlast2),
    .M_AXIS_TREADY2 (m_tready2)
`ifdef AXIS_BCAST_STATS_EN
    ,
    .beat_count     (beat_count),
    .pkt_count      (pkt_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: outputs pop before the input pushes, since a beat presented
  // now was accepted on an earlier edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid1 && m_tready1) begin
        if (exp1.size() == 0) chk("out1_unexpected_beat", 64'd1, 64'd0);
        else begin
          e1 = exp1.pop_front();
          chk("out1_data", 64'(m_tdata1), 64'(e1[DW:1]));
          chk("out1_last", 64'(m_tlast1), 64'(e1[0]));
        end
      end
      if (m_tvalid2 && m_tready2) begin
        if (exp2.size() == 0) chk("out2_unexpected_beat", 64'd1, 64'd0);
        else begin
          e2 = exp2.pop_front();
          chk("out2_data", 64'(m_tdata2), 64'(e2[DW:1]));
          chk("out2_last", 64'(m_tlast2), 64'(e2[0]));
        end
      end
      if (s_tvalid && s_tready) begin
        exp1.push_back({s_tdata, s_tlast});
        exp2.push_back({s_tdata, s_tlast});
      end
    end
  end

  // Random sink-ready driver, active only when rnd_rdy is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) begin
        m_tready1 = 1'($urandom_range(0, 1));
        m_tready2 = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Present one beat and hold it until accepted; returns at posedge+1 after
  // the accepting edge with TVALID dropped.
  task automatic send(input logic [DW-1:0] d, input logic l);
    logic a;
    int   n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n = 0;
    do begin
      @(negedge clk);
      a = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 1000);
    if (!a) chk("send_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp1.size() != 0 || exp2.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_q1_empty"}, 64'(exp1.size()), 64'd0);
    chk({name, "_q2_empty"}, 64'(exp2.size()), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rnd_rdy   = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = 32'hCAFE0001;
    s_tlast   = 1'b1;
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;

    // Reset state with TVALID asserted upstream.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("rst_tvalid2", 64'(m_tvalid2), 64'd0);
    chk("rst_tdata1", 64'(m_tdata1), 64'd0);
    chk("rst_tdata2", 64'(m_tdata2), 64'd0);
    chk("rst_tlast1", 64'(m_tlast1), 64'd0);
    s_tvalid = 1'b0;
    rst_n    = 1'b1;
    idle(1);
    chk("post_rst_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);

    // Streaming 1..8 back-to-back, last on 8, one-cycle latency, no gaps.
    fork
      begin
        for (int i = 1; i <= 8; i++) send(DW'(i), (i == 8));
      end
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!(s_tvalid && s_tready) && k < 20);
        for (int i = 1; i <= 8; i++) begin
          @(negedge clk);
          chk("stream_tvalid1", 64'(m_tvalid1), 64'd1);
          chk("stream_tvalid2", 64'(m_tvalid2), 64'd1);
          chk("stream_tdata1", 64'(m_tdata1), 64'(i));
          chk("stream_tdata2", 64'(m_tdata2), 64'(i));
          chk("stream_tlast1", 64'(m_tlast1), 64'(i == 8));
          chk("stream_tlast2", 64'(m_tlast2), 64'(i == 8));
        end
      end
    join
    idle(2);
    drain("stream");

    // Skewed sinks: output 2 stalled for 5 cycles.
    m_tready2 = 1'b0;
    send(32'hA5A5A5A5, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'h5A5A5A5A;
    s_tlast  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("skew_s_tready", 64'(s_tready), 64'd0);
      chk("skew_tvalid2", 64'(m_tvalid2), 64'd1);
      chk("skew_tdata2", 64'(m_tdata2), 64'hA5A5A5A5);
      chk("skew_tvalid1", 64'(m_tvalid1), 64'(c == 0));
    end
    @(posedge clk);
    #1;
    m_tready2 = 1'b1;
    send(32'h5A5A5A5A, 1'b1);
    @(negedge clk);
    chk("skew_new_tvalid1", 64'(m_tvalid1), 64'd1);
    chk("skew_new_tdata1", 64'(m_tdata1), 64'h5A5A5A5A);
    chk("skew_new_tdata2", 64'(m_tdata2), 64'h5A5A5A5A);
    idle(2);
    drain("skew");

    // Backpressure stability on both outputs.
    m_tready1 = 1'b0;
    m_tready2 = 1'b0;
    send(32'hDEADBEEF, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_tvalid1", 64'(m_tvalid1), 64'd1);
      chk("bp_tvalid2", 64'(m_tvalid2), 64'd1);
      chk("bp_tdata1", 64'(m_tdata1), 64'hDEADBEEF);
      chk("bp_tdata2", 64'(m_tdata2), 64'hDEADBEEF);
      chk("bp_s_tready", 64'(s_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;
    idle(2);
    drain("bp");

    // Asynchronous reset with a beat pending: outputs clear without a clock.
    m_tready1 = 1'b0;
    m_tready2 = 1'b0;
    send(32'h12345678, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp1.delete();
    exp2.delete();
    #1;
    chk("arst_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("arst_tvalid2", 64'(m_tvalid2), 64'd0);
    chk("arst_tdata1", 64'(m_tdata1), 64'd0);
    chk("arst_tlast2", 64'(m_tlast2), 64'd0);
    chk("arst_s_tready", 64'(s_tready), 64'd0);
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_empty_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("arst_empty_tvalid2", 64'(m_tvalid2), 64'd0);
    @(posedge clk);
    #1;

    // Random traffic with independent random sink readies.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      idle($urandom_range(0, 2));
      send($urandom, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;
    drain("random");

`ifdef AXIS_BCAST_STATS_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(1);
    for (int n = 0; n < 2000; n++) send(DW'(n), (n % 2 == 1));
    @(negedge clk);
    chk("stats_beat_count", 64'(beat_count), 64'd2000);
    chk("stats_pkt_count", 64'(pkt_count), 64'd1000);
    @(posedge clk);
    #1;
    force dut.beat_cnt_q = 32'hFFFFFFFF;
    force dut.pkt_cnt_q  = 32'hFFFFFFFF;
    #1;
    release dut.beat_cnt_q;
    release dut.pkt_cnt_q;
    send(32'h0BADF00D, 1'b1);
    @(negedge clk);
    chk("stats_beat_wrap", 64'(beat_count), 64'd0);
    chk("stats_pkt_wrap", 64'(pkt_count), 64'd0);
    idle(2);
    drain("stats");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
